i_execute: RTL and testbench

- Execute (EX) stage of the 5-stage MIPS pipeline; sits directly downstream of the decode stage and consumes its ID/EX-registered outputs.
- Contains ALU-control decode, a 32-bit ALU, the branch-target adder and the write-register mux.
- Ends in an EX/MEM pipeline register that feeds the memory stage.

---
 rtl/i_execute_if.sv | 48 ++++
 rtl/i_execute.sv | 73 +++++++
 tb/tb_i_execute.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/i_execute_if.sv
// i_execute_if: ID/EX inputs and EX/MEM outputs of the execute stage (flush present with EXMEM_FLUSH_EN)
interface i_execute_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] nPC;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] SE;
  logic [4:0]       RT;
  logic [4:0]       RD;
  logic [1:0]       ALUOp;
  logic             ALUSrc;
  logic             RegDst;
  logic             Branch;
  logic             MemRead;
  logic             MemWrite;
  logic             MemtoReg;
  logic             RegWrite;
`ifdef EXMEM_FLUSH_EN
  logic             flush;
`endif
  logic [WIDTH-1:0] BranchTarget;
  logic             Zero;
  logic [WIDTH-1:0] ALUResult;
  logic [WIDTH-1:0] WriteData;
  logic [4:0]       WriteAddress;
  logic             BranchOut;
  logic             MemReadOut;
  logic             MemWriteOut;
  logic             MemtoRegOut;
  logic             RegWriteOut;
  modport master (
    output nPC, A, B, SE, RT, RD, ALUOp, ALUSrc, RegDst,
           Branch, MemRead, MemWrite, MemtoReg, RegWrite,
`ifdef EXMEM_FLUSH_EN
           flush,
`endif
    input  BranchTarget, Zero, ALUResult, WriteData, WriteAddress,
           BranchOut, MemReadOut, MemWriteOut, MemtoRegOut, RegWriteOut
  );
  modport slave (
    input  nPC, A, B, SE, RT, RD, ALUOp, ALUSrc, RegDst,
           Branch, MemRead, MemWrite, MemtoReg, RegWrite,
`ifdef EXMEM_FLUSH_EN
           flush,
`endif
    output BranchTarget, Zero, ALUResult, WriteData, WriteAddress,
           BranchOut, MemReadOut, MemWriteOut, MemtoRegOut, RegWriteOut
  );
endinterface

// File: rtl/i_execute.sv
// i_execute: MIPS EX stage (ALU control, ALU, branch adder, dest mux) ending in EX/MEM register; EXMEM_FLUSH_EN adds control-bit flush
module i_execute #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  i_execute_if.slave bus
);
  logic [WIDTH-1:0] op2, sum, diff, slt, rtype;
  logic [5:0]       funct;
  logic             flush_w;
  logic [WIDTH-1:0] branch_target_d, branch_target_q;
  logic [WIDTH-1:0] alu_result_d, alu_result_q;
  logic [WIDTH-1:0] write_data_d, write_data_q;
  logic [4:0]       write_address_d, write_address_q;
  logic             zero_d, zero_q;
  logic [4:0]       ctl_d, ctl_q;
`ifdef EXMEM_FLUSH_EN
  assign flush_w = bus.flush;
`else
  assign flush_w = 1'b0;
`endif
  // ALU, branch target, destination mux and control bits for the EX/MEM register
  always_comb begin
    op2             = bus.ALUSrc ? bus.SE : bus.B;
    funct           = bus.SE[5:0];
    sum             = bus.A + op2;
    diff            = bus.A - op2;
    slt             = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(op2)};
    rtype           = funct == 6'b100000 ? sum :
                      funct == 6'b100010 ? diff :
                      funct == 6'b100100 ? (bus.A & op2) :
                      funct == 6'b100101 ? (bus.A | op2) :
                      funct == 6'b101010 ? slt : '0;
    alu_result_d    = bus.ALUOp == 2'b00 ? sum :
                      bus.ALUOp == 2'b01 ? diff :
                      bus.ALUOp == 2'b10 ? rtype : '0;
    zero_d          = alu_result_d == '0;
    branch_target_d = bus.nPC + {bus.SE[WIDTH-3:0], 2'b00};
    write_data_d    = bus.B;
    write_address_d = bus.RegDst ? bus.RD : bus.RT;
    ctl_d           = flush_w ? 5'b0 :
                      {bus.Branch, bus.MemRead, bus.MemWrite, bus.MemtoReg, bus.RegWrite};
  end
  // EX/MEM register: captures every edge, cleared asynchronously to a NOP bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_target_q <= '0;
      alu_result_q    <= '0;
      write_data_q    <= '0;
      write_address_q <= '0;
      zero_q          <= 1'b0;
      ctl_q           <= '0;
    end else begin
      branch_target_q <= branch_target_d;
      alu_result_q    <= alu_result_d;
      write_data_q    <= write_data_d;
      write_address_q <= write_address_d;
      zero_q          <= zero_d;
      ctl_q           <= ctl_d;
    end
  end
  assign bus.BranchTarget = branch_target_q;
  assign bus.Zero         = zero_q;
  assign bus.ALUResult    = alu_result_q;
  assign bus.WriteData    = write_data_q;
  assign bus.WriteAddress = write_address_q;
  assign bus.BranchOut    = ctl_q[4];
  assign bus.MemReadOut   = ctl_q[3];
  assign bus.MemWriteOut  = ctl_q[2];
  assign bus.MemtoRegOut  = ctl_q[1];
  assign bus.RegWriteOut  = ctl_q[0];
endmodule

// File: tb/tb_i_execute.sv
// tb_i_execute: scoreboard bench for i_execute (flush cases run when EXMEM_FLUSH_EN is defined)
module tb_i_execute;
  typedef struct packed {
    logic [31:0] npc, a, b, se;
    logic [4:0]  rt, rd;
    logic [1:0]  aluop;
    logic        alusrc, regdst;
    logic [4:0]  ctl;
    logic        flush;
  } stim_t;
  typedef struct packed {
    logic [31:0] bt, alu, wd;
    logic        z;
    logic [4:0]  wa, ctl;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  exp_t sb[$];
  i_execute_if #(.WIDTH(32)) bus();
  i_execute #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input stim_t s);
    exp_t e;
    logic [31:0] o2;
    o2 = s.alusrc ? s.se : s.b;
    case (s.aluop)
      2'b00: e.alu = s.a + o2;
      2'b01: e.alu = s.a - o2;
      2'b10:
        case (s.se[5:0])
          6'h20: e.alu = s.a + o2;
          6'h22: e.alu = s.a - o2;
          6'h24: e.alu = s.a & o2;
          6'h25: e.alu = s.a | o2;
          6'h2a: e.alu = ($signed(s.a) < $signed(o2)) ? 32'd1 : 32'd0;
          default: e.alu = 32'd0;
        endcase
      default: e.alu = 32'd0;
    endcase
    e.z   = (e.alu == 32'd0);
    e.bt  = s.npc + (s.se * 4);
    e.wd  = s.b;
    e.wa  = s.regdst ? s.rd : s.rt;
`ifdef EXMEM_FLUSH_EN
    e.ctl = s.flush ? 5'b0 : s.ctl;
`else
    e.ctl = s.ctl;
`endif
    return e;
  endfunction
  task automatic drive(input stim_t s);
    bus.nPC = s.npc; bus.A = s.a; bus.B = s.b; bus.SE = s.se;
    bus.RT = s.rt; bus.RD = s.rd; bus.ALUOp = s.aluop;
    bus.ALUSrc = s.alusrc; bus.RegDst = s.regdst;
    {bus.Branch, bus.MemRead, bus.MemWrite, bus.MemtoReg, bus.RegWrite} = s.ctl;
`ifdef EXMEM_FLUSH_EN
    bus.flush = s.flush;
`endif
  endtask
  function automatic logic [4:0] ctl_out();
    return {bus.BranchOut, bus.MemReadOut, bus.MemWriteOut, bus.MemtoRegOut, bus.RegWriteOut};
  endfunction
  task automatic apply(input string tag, input stim_t s);
    exp_t e;
    @(negedge clk);
    drive(s);
    sb.push_back(model(s));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, " sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, " alu"}, bus.ALUResult, e.alu);
      chk({tag, " zero"}, {31'd0, bus.Zero}, {31'd0, e.z});
      chk({tag, " bt"}, bus.BranchTarget, e.bt);
      chk({tag, " wd"}, bus.WriteData, e.wd);
      chk({tag, " wa"}, {27'd0, bus.WriteAddress}, {27'd0, e.wa});
      chk({tag, " ctl"}, {27'd0, ctl_out()}, {27'd0, e.ctl});
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " alu"}, bus.ALUResult, 32'd0);
    chk({tag, " zero"}, {31'd0, bus.Zero}, 32'd0);
    chk({tag, " bt"}, bus.BranchTarget, 32'd0);
    chk({tag, " wd"}, bus.WriteData, 32'd0);
    chk({tag, " wa"}, {27'd0, bus.WriteAddress}, 32'd0);
    chk({tag, " ctl"}, {27'd0, ctl_out()}, 32'd0);
  endtask
  function automatic stim_t rnd();
    stim_t s;
    logic [5:0] fn [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h3f};
    s.npc = $urandom; s.a = $urandom; s.se = $urandom;
    s.b = ($urandom_range(0, 3) == 0) ? s.a : $urandom;
    s.se[5:0] = fn[$urandom_range(0, 6)];
    s.rt = 5'($urandom); s.rd = 5'($urandom);
    s.aluop = 2'($urandom); s.alusrc = 1'($urandom); s.regdst = 1'($urandom);
    s.ctl = 5'($urandom); s.flush = 1'b0;
    return s;
  endfunction
  initial begin
    stim_t s, s2;
    drive(rnd());
    #1 reset = 1'b1;
    #1 chk_zero("rst_pre");
    @(posedge clk);
    #1 chk_zero("rst_post");
    @(negedge clk);
    reset = 1'b0;
    s = '0; s.a = 32'd5; s.b = 32'd7; s.se = 32'h20; s.aluop = 2'b10;
    s.regdst = 1'b1; s.rd = 5'd9; s.rt = 5'd3; s.ctl = 5'b00001;
    apply("radd", s);
    chk("radd_const", bus.ALUResult, 32'd12);
    chk("radd_wa", {27'd0, bus.WriteAddress}, 32'd9);
    s = '0; s.a = 32'h100; s.se = 32'hFFFFFFFC; s.alusrc = 1'b1; s.rt = 5'd4;
    s.rd = 5'd17; s.ctl = 5'b01000;
    apply("lw", s);
    chk("lw_const", bus.ALUResult, 32'hFC);
    s = '0; s.a = 32'h1234; s.b = 32'h1234; s.aluop = 2'b01; s.npc = 32'h40;
    s.se = 32'hFFFFFFFE; s.ctl = 5'b10000;
    apply("beq", s);
    chk("beq_bt", bus.BranchTarget, 32'h38);
    chk("beq_z", {31'd0, bus.Zero}, 32'd1);
    s = '0; s.a = 32'hFFFFFFFF; s.b = 32'd1; s.aluop = 2'b10; s.se = 32'h2a;
    apply("slt", s);
    chk("slt_const", bus.ALUResult, 32'd1);
    s.se = 32'h20;
    apply("wrap", s);
    chk("wrap_z", {31'd0, bus.Zero}, 32'd1);
    s.se = 32'h0;
    apply("unk", s);
    chk("unk_z", {31'd0, bus.Zero}, 32'd1);
    s.aluop = 2'b11; s.se = 32'h20;
    apply("op11", s);
    for (int i = 0; i < 24; i++) apply($sformatf("rnd%0d", i), rnd());
    s = '0; s.a = 32'd5; s.b = 32'd7; s.se = 32'h20; s.aluop = 2'b10;
    s.regdst = 1'b1; s.rd = 5'd9; s.ctl = 5'b11111; s.npc = 32'h10;
    apply("pre_rst", s);
    reset = 1'b1;
    #1 chk_zero("rst_async");
    @(negedge clk);
    reset = 1'b0;
`ifdef EXMEM_FLUSH_EN
    s2 = s; s2.a = 32'd40; s2.b = 32'd2; s2.se = 32'h22; s2.flush = 1'b1;
    apply("fl_first", s);
    chk("fl_first_ctl", {27'd0, ctl_out()}, 32'h1f);
    apply("fl_second", s2);
    chk("fl_second_ctl", {27'd0, ctl_out()}, 32'd0);
    chk("fl_second_alu", bus.ALUResult, 32'd38);
    s.flush = 1'b0;
    apply("fl_after", s);
`else
    s2 = s; s2.a = 32'd40; s2.b = 32'd2; s2.se = 32'h22;
    apply("b2b_first", s);
    apply("b2b_second", s2);
    chk("b2b_second_ctl", {27'd0, ctl_out()}, 32'h1f);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
